// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared definitions for the systolic mesh feeder: default
//                mesh geometry, accumulator width, feeder state encoding and
//                the element type.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int N_DEF      = 4;                 // mesh dimension
    localparam int DATA_W_DEF = 4;                 // signed element width
    localparam int ACC_W      = 2*DATA_W_DEF + 1;  // PE accumulator width

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    typedef logic signed [DATA_W_DEF-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : feeder_bank
//  Description : NxN element store. One full row is written per cycle; each
//                read lane returns element [rd_row][rd_col] combinationally.
//                A matrices are stored row-wise, B matrices column-wise, so
//                "row" here is whichever vector the load beat carried.
//  Ports       : clk      - clock
//                wr_en    - write the row addressed by wr_row
//                wr_row   - row index
//                wr_data  - row contents, element e at [e*DATA_W +: DATA_W]
//                rd_row   - per-lane row index (lane l at [l*IW +: IW])
//                rd_col   - per-lane column index
//                rd_data  - per-lane element (lane l at [l*DATA_W +: DATA_W])
//  Revision    : 1.0 - initial release
// ============================================================================
module feeder_bank
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_row,
    input  logic [N*DATA_W-1:0] wr_data,
    input  logic [N*IW-1:0]     rd_row,
    input  logic [N*IW-1:0]     rd_col,
    output logic [N*DATA_W-1:0] rd_data
);

    logic [N*DATA_W-1:0] r_mem [N];

    // Data store only: contents are always fully rewritten by a load before
    // they are streamed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_row] <= wr_data;
        end
    end

    for (genvar l = 0; l < N; l++) begin : g_rd_lane
        assign rd_data[l*DATA_W +: DATA_W] =
            r_mem[rd_row[l*IW +: IW]][rd_col[l*IW +: IW]*DATA_W +: DATA_W];
    end

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_skew_feeder
//  Description : Upstream feeder for an NxN systolic PE mesh. Buffers A
//                (row per beat, beats 0..N-1) and B (column per beat, beats
//                N..2N-1), clears the mesh for one cycle, then streams the
//                diagonally skewed A rows on a_edge and B columns on b_edge
//                for 3N-2 cycles, followed by a one-cycle DRAIN with done.
//  Config      : SKEW_FEEDER_DBUF_EN - active/shadow bank pairs; loading is
//                allowed in every state while the shadow bank has room, and
//                a full shadow bank chains straight from DRAIN into CLEAR.
//  Ports       : clk, reset (synchronous, active-high)
//                load_valid/load_ready/load_data - load beat handshake
//                a_edge  - lane i drives in_a of PE(i,0), registered
//                b_edge  - lane j drives in_b of PE(0,j), registered
//                pe_clear- one-cycle mesh clear
//                busy    - high in CLEAR/STREAM/DRAIN
//                done    - one-cycle pulse, mesh results final
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [N*DATA_W-1:0] load_data,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic                pe_clear,
    output logic                busy,
    output logic                done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(2*N + 1);
    localparam int TW = $clog2(3*N);
    localparam int LW = N*DATA_W;

    localparam logic [CW-1:0] c_beats     = CW'(2*N);
    localparam logic [CW-1:0] c_last_beat = CW'(2*N - 1);
    localparam logic [TW-1:0] c_t_last    = TW'(3*N - 3);

    feeder_state_t   r_state;
    feeder_state_t   w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [TW-1:0]   r_t;
    logic [TW-1:0]   w_t_next;
    logic            w_ready;
    logic            w_accept;
    logic            w_full;
    logic            w_stream_next;
    logic            w_wr_a;
    logic            w_wr_b;
    logic [IW-1:0]   w_wr_row;
    logic [N*IW-1:0] w_rd_row;
    logic [N*IW-1:0] w_rd_col;
    logic [LW-1:0]   w_a_rd;
    logic [LW-1:0]   w_b_rd;
    logic [LW-1:0]   w_a_next;
    logic [LW-1:0]   w_b_next;
    logic [LW-1:0]   r_a_edge;
    logic [LW-1:0]   r_b_edge;
    logic [N-1:0]    w_lane_ok;

    // ------------------------------------------------------------------
    // Load port. r_cnt counts beats held in the bank being filled.
    // ------------------------------------------------------------------
    assign w_accept = load_valid & w_ready;
    assign w_wr_a   = w_accept && (r_cnt <  CW'(N));
    assign w_wr_b   = w_accept && (r_cnt >= CW'(N));
    assign w_wr_row = IW'((r_cnt < CW'(N)) ? r_cnt : r_cnt - CW'(N));

`ifdef SKEW_FEEDER_DBUF_EN
    logic r_active;
    logic w_swap;

    assign w_ready = (r_cnt != c_beats);
    // Shadow bank is (or becomes on this edge) a complete job.
    assign w_full  = (r_cnt == c_beats) || (w_accept && (r_cnt == c_last_beat));
`else
    assign w_ready = (r_state == LOAD);
    assign w_full  = w_accept && (r_cnt == c_last_beat);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_t_next     = r_t;
        w_cnt_next   = w_accept ? (r_cnt + CW'(1)) : r_cnt;
`ifdef SKEW_FEEDER_DBUF_EN
        w_swap       = 1'b0;
`endif
        case (r_state)
            LOAD: begin
                if (w_full) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
`ifdef SKEW_FEEDER_DBUF_EN
                    w_swap       = 1'b1;
`endif
                end
            end
            CLEAR: begin
                w_state_next = STREAM;
                w_t_next     = '0;
            end
            STREAM: begin
                w_t_next = r_t + TW'(1);
                if (r_t == c_t_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_t_next = '0;
`ifdef SKEW_FEEDER_DBUF_EN
                if (w_full) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                    w_swap       = 1'b1;
                end else begin
                    w_state_next = LOAD;
                end
`else
                w_state_next = LOAD;
`endif
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skew generation. Edges are registered, so the value for the cycle
    // after this edge is computed from the next state and next t. Both
    // banks hold the streamed vector as a "row" (A row i, B column j), so
    // lane l reads element [l][t-l] from each.
    // ------------------------------------------------------------------
    assign w_stream_next = (w_state_next == STREAM);

    for (genvar l = 0; l < N; l++) begin : g_lane
        assign w_lane_ok[l] = w_stream_next &&
                              (int'(w_t_next) >= l) &&
                              (int'(w_t_next) <  l + N);
        assign w_rd_row[l*IW +: IW] = IW'(l);
        assign w_rd_col[l*IW +: IW] = IW'(int'(w_t_next) - l);
        assign w_a_next[l*DATA_W +: DATA_W] =
            w_lane_ok[l] ? w_a_rd[l*DATA_W +: DATA_W] : '0;
        assign w_b_next[l*DATA_W +: DATA_W] =
            w_lane_ok[l] ? w_b_rd[l*DATA_W +: DATA_W] : '0;
    end

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
`ifdef SKEW_FEEDER_DBUF_EN
    logic [LW-1:0] w_a_rd_bank [2];
    logic [LW-1:0] w_b_rd_bank [2];

    // Loads always target the shadow bank (index != r_active).
    for (genvar s = 0; s < 2; s++) begin : g_bank
        feeder_bank #(.N(N), .DATA_W(DATA_W), .IW(IW)) u_bank_a (
            .clk     (clk),
            .wr_en   (w_wr_a && (r_active != 1'(s))),
            .wr_row  (w_wr_row),
            .wr_data (load_data),
            .rd_row  (w_rd_row),
            .rd_col  (w_rd_col),
            .rd_data (w_a_rd_bank[s])
        );
        feeder_bank #(.N(N), .DATA_W(DATA_W), .IW(IW)) u_bank_b (
            .clk     (clk),
            .wr_en   (w_wr_b && (r_active != 1'(s))),
            .wr_row  (w_wr_row),
            .wr_data (load_data),
            .rd_row  (w_rd_row),
            .rd_col  (w_rd_col),
            .rd_data (w_b_rd_bank[s])
        );
    end

    assign w_a_rd = r_active ? w_a_rd_bank[1] : w_a_rd_bank[0];
    assign w_b_rd = r_active ? w_b_rd_bank[1] : w_b_rd_bank[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
        end else if (w_swap) begin
            r_active <= ~r_active;
        end
    end
`else
    feeder_bank #(.N(N), .DATA_W(DATA_W), .IW(IW)) u_bank_a (
        .clk     (clk),
        .wr_en   (w_wr_a),
        .wr_row  (w_wr_row),
        .wr_data (load_data),
        .rd_row  (w_rd_row),
        .rd_col  (w_rd_col),
        .rd_data (w_a_rd)
    );
    feeder_bank #(.N(N), .DATA_W(DATA_W), .IW(IW)) u_bank_b (
        .clk     (clk),
        .wr_en   (w_wr_b),
        .wr_row  (w_wr_row),
        .wr_data (load_data),
        .rd_row  (w_rd_row),
        .rd_col  (w_rd_col),
        .rd_data (w_b_rd)
    );
`endif

    // ------------------------------------------------------------------
    // State and edge registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= LOAD;
            r_cnt    <= '0;
            r_t      <= '0;
            r_a_edge <= '0;
            r_b_edge <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_t      <= w_t_next;
            r_a_edge <= w_a_next;
            r_b_edge <= w_b_next;
        end
    end

    assign load_ready = w_ready;
    assign a_edge     = r_a_edge;
    assign b_edge     = r_b_edge;
    assign pe_clear   = (r_state == CLEAR);
    assign busy       = (r_state != LOAD);
    assign done       = (r_state == DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Self-checking bench for systolic_skew_feeder. Expected edge
//                values come from the skew formula applied to the bench's own
//                matrices; a behavioural mesh built from the observed edges
//                is compared to a direct matrix product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    localparam int N      = N_DEF;
    localparam int DW     = DATA_W_DEF;
    localparam int LW     = N*DW;
    localparam int T_LAST = 3*N - 2;   // DRAIN cycle index

    typedef int mat_t [N][N];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [LW-1:0] load_data = '0;
    logic          load_ready;
    logic [LW-1:0] a_edge;
    logic [LW-1:0] b_edge;
    logic          pe_clear;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .a_edge     (a_edge),
        .b_edge     (b_edge),
        .pe_clear   (pe_clear),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference helpers ----------------
    function automatic logic [LW-1:0] beat_word(input mat_t a, input mat_t b, input int beat);
        logic [LW-1:0] w;
        w = '0;
        for (int e = 0; e < N; e++) begin
            if (beat < N) w[e*DW +: DW] = DW'(a[beat][e]);
            else          w[e*DW +: DW] = DW'(b[e][beat-N]);
        end
        return w;
    endfunction

    function automatic logic [LW-1:0] exp_a(input mat_t a, input int t);
        logic [LW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) w[i*DW +: DW] = DW'(a[i][t-i]);
        return w;
    endfunction

    function automatic logic [LW-1:0] exp_b(input mat_t b, input int t);
        logic [LW-1:0] w;
        w = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) w[j*DW +: DW] = DW'(b[t-j][j]);
        return w;
    endfunction

    function automatic int sx(input logic [DW-1:0] v);
        logic signed [DW-1:0] s;
        s = v;
        return int'(s);
    endfunction

    function automatic int wrap_acc(input int v);
        logic signed [ACC_W-1:0] x;
        x = ACC_W'(v);
        return int'(x);
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic load_job(input mat_t a, input mat_t b, input bit rnd);
        int beat = 0;
        int cyc  = 0;
        bit v;
        while (beat < 2*N && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("load_ready_in_load", 32'(load_ready), 32'(1));
            chk("load_busy_low", 32'(busy), 32'(0));
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            load_valid = v;
            load_data  = v ? beat_word(a, b, beat) : LW'($urandom);
            if (v && load_ready) beat++;
        end
        chk("load_beats", 32'(beat), 32'(2*N));
    endtask

    // Side-port activity while a job runs: either loading the next job
    // (double-buffered) or offering junk that must be ignored.
    task automatic side_drive(input bit chain, inout int beat2, input mat_t a2, input mat_t b2);
        if (chain) begin
            chk("dbuf_ready", 32'(load_ready), 32'(beat2 < 2*N));
            load_valid = (beat2 < 2*N);
            load_data  = beat_word(a2, b2, beat2 < 2*N ? beat2 : 0);
            if (load_valid && load_ready) beat2++;
        end else begin
`ifdef SKEW_FEEDER_DBUF_EN
            chk("dbuf_idle_ready", 32'(load_ready), 32'(1));
            load_valid = 1'b0;
`else
            chk("busy_ready_low", 32'(load_ready), 32'(0));
            load_valid = 1'b1;
            load_data  = LW'($urandom);
`endif
        end
    endtask

    task automatic run_job(input mat_t a, input mat_t b, input bit chain,
                           input mat_t a2, input mat_t b2, output bit chained);
        logic [LW-1:0] a_hist [T_LAST+1];
        logic [LW-1:0] b_hist [T_LAST+1];
        int beat2 = 0;
        int s, r;
        // CLEAR
        @(negedge clk);
        chk("clear_pulse", 32'(pe_clear), 32'(1));
        chk("clear_busy", 32'(busy), 32'(1));
        chk("clear_done", 32'(done), 32'(0));
        chk("clear_a_edge", 32'(a_edge), 32'(0));
        chk("clear_b_edge", 32'(b_edge), 32'(0));
        side_drive(chain, beat2, a2, b2);
        // STREAM t = 0 .. 3N-3
        for (int t = 0; t < T_LAST; t++) begin
            @(negedge clk);
            chk("stream_clear", 32'(pe_clear), 32'(0));
            chk("stream_done", 32'(done), 32'(0));
            chk("stream_busy", 32'(busy), 32'(1));
            chk($sformatf("a_edge_t%0d", t), 32'(a_edge), 32'(exp_a(a, t)));
            chk($sformatf("b_edge_t%0d", t), 32'(b_edge), 32'(exp_b(b, t)));
            a_hist[t] = a_edge;
            b_hist[t] = b_edge;
            side_drive(chain, beat2, a2, b2);
        end
        // DRAIN
        @(negedge clk);
        chk("drain_done", 32'(done), 32'(1));
        chk("drain_busy", 32'(busy), 32'(1));
        chk("drain_a_edge", 32'(a_edge), 32'(0));
        chk("drain_b_edge", 32'(b_edge), 32'(0));
        a_hist[T_LAST] = a_edge;
        b_hist[T_LAST] = b_edge;
        side_drive(chain, beat2, a2, b2);
        // Behavioural mesh: PE(i,j) sees a_edge lane i delayed j cycles and
        // b_edge lane j delayed i cycles.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                r = 0;
                for (int t = 0; t <= T_LAST; t++)
                    if (t - j >= 0 && t - i >= 0)
                        s += sx(a_hist[t-j][i*DW +: DW]) * sx(b_hist[t-i][j*DW +: DW]);
                for (int k = 0; k < N; k++) r += a[i][k] * b[k][j];
                chk($sformatf("c_%0d_%0d", i, j), 32'(wrap_acc(s)), 32'(wrap_acc(r)));
            end
        end
        chained = chain && (beat2 == 2*N);
        if (chain) chk("dbuf_job2_loaded", 32'(beat2), 32'(2*N));
        if (!chained) begin
            @(negedge clk);
            load_valid = 1'b0;
            chk("post_load_busy", 32'(busy), 32'(0));
            chk("post_load_done", 32'(done), 32'(0));
            chk("post_load_ready", 32'(load_ready), 32'(1));
        end
    endtask

    // ---------------- test sequence ----------------
    mat_t ma, mb, ma2, mb2;
    bit   chained;

    task automatic rand_mat(output mat_t m);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = int'($urandom_range(0, 15)) - 8;
    endtask

    initial begin
        // 1. reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_load_ready", 32'(load_ready), 32'(1));
        chk("rst_a_edge", 32'(a_edge), 32'(0));
        chk("rst_b_edge", 32'(b_edge), 32'(0));
        chk("rst_pe_clear", 32'(pe_clear), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        reset = 1'b0;

        // 2. identity x (B[k][j] = j+1)
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = j + 1;
            end
        load_job(ma, mb, 1'b0);
        run_job(ma, mb, 1'b0, ma, mb, chained);

        // 3. all -1 x all 1
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = -1;
                mb[i][j] = 1;
            end
        load_job(ma, mb, 1'b1);
        run_job(ma, mb, 1'b0, ma, mb, chained);

        // 4. random matrices with random valid toggling
        for (int n = 0; n < 4; n++) begin
            rand_mat(ma);
            rand_mat(mb);
            load_job(ma, mb, 1'b1);
            run_job(ma, mb, 1'b0, ma, mb, chained);
        end

        // 5. reset at STREAM t=4
        rand_mat(ma);
        rand_mat(mb);
        load_job(ma, mb, 1'b1);
        @(negedge clk);                       // CLEAR
        load_valid = 1'b0;
        chk("abort_clear_seen", 32'(pe_clear), 32'(1));
        repeat (5) @(negedge clk);            // t = 0..4
        chk("abort_t4_a_edge", 32'(a_edge), 32'(exp_a(ma, 4)));
        reset      = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_a_edge", 32'(a_edge), 32'(0));
        chk("abort_b_edge", 32'(b_edge), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_pe_clear", 32'(pe_clear), 32'(0));
        chk("abort_ready", 32'(load_ready), 32'(1));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'(0));
            chk("abort_idle", 32'(busy), 32'(0));
        end
        rand_mat(ma);
        rand_mat(mb);
        load_job(ma, mb, 1'b1);
        run_job(ma, mb, 1'b0, ma, mb, chained);

`ifdef SKEW_FEEDER_DBUF_EN
        // 6. back-to-back jobs: job2 loaded during job1 stream
        rand_mat(ma);
        rand_mat(mb);
        rand_mat(ma2);
        rand_mat(mb2);
        load_job(ma, mb, 1'b0);
        run_job(ma, mb, 1'b1, ma2, mb2, chained);
        chk("dbuf_chained", 32'(chained), 32'(1));
        run_job(ma2, mb2, 1'b0, ma2, mb2, chained);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
